// File: rtl/secuenciador_micro_pkg.sv
// -----------------------------------------------------------------------------
// secuenciador_micro_pkg
// Shared definitions for the microsequencer: FSM state encoding, microword
// field positions, branch condition codes and default parameter values.
// No ports (package).
// -----------------------------------------------------------------------------
package secuenciador_micro_pkg;

  // Default sizing of the microprogram and of the wait timeout.
  localparam int ULTIMA_DIR_DEF   = 49;
  localparam int MAX_ESPERA_DEF   = 255;
  localparam int ANCHO_ESPERA_DEF = 8;

  // Microword layout (10 bits).
  localparam int BIT_SALTO  = 9;
  localparam int BIT_VALIDO = 8;
  localparam int COND_HI    = 7;
  localparam int COND_LO    = 6;
  localparam int DEST_HI    = 5;
  localparam int DEST_LO    = 0;

  // Branch condition select codes.
  localparam logic [1:0] COND_SIEMPRE = 2'b00;
  localparam logic [1:0] COND_C0      = 2'b01;
  localparam logic [1:0] COND_C1      = 2'b10;
  localparam logic [1:0] COND_ESPERA  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    STALL = 3'd3,
    FIN   = 3'd4
  } estado_t;

endpackage

// File: rtl/secuenciador_micro_decodificador.sv
// -----------------------------------------------------------------------------
// decodificador_microinstruccion
// Purely combinational decode of one microword against the live status flags.
// Ports:
//   i_micro        [9:0]  microword held in the instruction register
//   i_cond         [2:0]  datapath status flags (Condiciones)
//   o_es_halt             microword is HALT
//   o_es_control          microword is CONTROL
//   o_salto_tomado        BRANCH whose condition holds now (includes a WAIT
//                         whose release flag is already high)
//   o_es_espera           BRANCH with the WAIT condition code
//   o_destino      [5:0]  branch target
// -----------------------------------------------------------------------------
module decodificador_microinstruccion
  import secuenciador_micro_pkg::*;
(
  input  logic [9:0] i_micro,
  input  logic [2:0] i_cond,
  output logic       o_es_halt,
  output logic       o_es_control,
  output logic       o_salto_tomado,
  output logic       o_es_espera,
  output logic [5:0] o_destino
);

  logic       w_es_salto;
  logic [1:0] w_sel;

  assign w_es_salto   = i_micro[BIT_VALIDO] & i_micro[BIT_SALTO];
  assign w_sel        = i_micro[COND_HI:COND_LO];
  assign o_es_halt    = ~i_micro[BIT_VALIDO];
  assign o_es_control = i_micro[BIT_VALIDO] & ~i_micro[BIT_SALTO];
  assign o_es_espera  = w_es_salto & (w_sel == COND_ESPERA);
  assign o_destino    = i_micro[DEST_HI:DEST_LO];

  always_comb begin
    o_salto_tomado = 1'b0;
    if (w_es_salto) begin
      case (w_sel)
        COND_SIEMPRE: o_salto_tomado = 1'b1;
        COND_C0:      o_salto_tomado = i_cond[0];
        COND_C1:      o_salto_tomado = i_cond[1];
        COND_ESPERA:  o_salto_tomado = i_cond[2];
        default:      o_salto_tomado = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/secuenciador_micro.sv
// -----------------------------------------------------------------------------
// secuenciador_micro
// Microsequencer: addresses a 64-entry microprogram memory, fetches and
// executes one microword every two cycles (FETCH + EXEC) and emits one
// registered 8-bit control word per executed CONTROL microword.
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   Inicio, Dir_Inicio[5:0]    start request and entry address (IDLE only)
//   Abortar                    abort; wins over everything but reset
//   Condiciones[2:0]           datapath status flags
//   Dir_Memoria_Micro[5:0]     registered microprogram address (uPC)
//   Data_Memoria_Micro[9:0]    microword read combinationally from memory
//   Senales_Control[7:0]       control word, non-zero for one cycle per CONTROL
//   Ocupado                    program running
//   Listo                      one-cycle pulse on normal completion
//   Error_Tiempo               sticky: wait timeout or illegal address
// Senales_Control carries no separate valid: a cycle holding a control word is
// exactly the cycle after a CONTROL EXEC; every other cycle it is zero.
// -----------------------------------------------------------------------------
module secuenciador_micro
  import secuenciador_micro_pkg::*;
#(
  parameter int ULTIMA_DIR   = ULTIMA_DIR_DEF,
  parameter int MAX_ESPERA   = MAX_ESPERA_DEF,
  parameter int ANCHO_ESPERA = ANCHO_ESPERA_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Inicio,
  input  logic [5:0] Dir_Inicio,
  input  logic       Abortar,
  input  logic [2:0] Condiciones,
  output logic [5:0] Dir_Memoria_Micro,
  input  logic [9:0] Data_Memoria_Micro,
  output logic [7:0] Senales_Control,
  output logic       Ocupado,
  output logic       Listo,
  output logic       Error_Tiempo
);

  localparam logic [5:0]              ULTIMA    = 6'(ULTIMA_DIR);
  localparam logic [ANCHO_ESPERA-1:0] CNT_LIMITE = ANCHO_ESPERA'(MAX_ESPERA - 1);

  estado_t                 r_estado, w_estado_sig;
  logic [5:0]              r_upc, w_upc_sig;
  logic [9:0]              r_ir, w_ir_sig;
  logic [ANCHO_ESPERA-1:0] r_cnt, w_cnt_sig;
  logic [7:0]              r_senales, w_senales_sig;
  logic                    r_ocupado, w_ocupado_sig;
  logic                    r_listo, w_listo_sig;
  logic                    r_error, w_error_sig;

  logic       w_es_halt, w_es_control, w_salto_tomado, w_es_espera;
  logic [5:0] w_destino;
  logic       w_destino_ilegal;

  decodificador_microinstruccion u_dec (
    .i_micro        (r_ir),
    .i_cond         (Condiciones),
    .o_es_halt      (w_es_halt),
    .o_es_control   (w_es_control),
    .o_salto_tomado (w_salto_tomado),
    .o_es_espera    (w_es_espera),
    .o_destino      (w_destino)
  );

  assign w_destino_ilegal = (w_destino > ULTIMA);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= IDLE;
      r_upc     <= '0;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_senales <= '0;
      r_ocupado <= 1'b0;
      r_listo   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_estado  <= w_estado_sig;
      r_upc     <= w_upc_sig;
      r_ir      <= w_ir_sig;
      r_cnt     <= w_cnt_sig;
      r_senales <= w_senales_sig;
      r_ocupado <= w_ocupado_sig;
      r_listo   <= w_listo_sig;
      r_error   <= w_error_sig;
    end
  end

  always_comb begin
    w_estado_sig  = r_estado;
    w_upc_sig     = r_upc;
    w_ir_sig      = r_ir;
    w_cnt_sig     = '0;          // the stall counter only survives while staying in STALL
    w_senales_sig = '0;
    w_ocupado_sig = r_ocupado;
    w_listo_sig   = 1'b0;
    w_error_sig   = r_error;

    if (Abortar) begin
      w_estado_sig  = IDLE;
      w_ocupado_sig = 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (Inicio) begin
            if (Dir_Inicio > ULTIMA) begin
              w_error_sig = 1'b1;
            end else begin
              w_upc_sig     = Dir_Inicio;
              w_ocupado_sig = 1'b1;
              w_error_sig   = 1'b0;
              w_estado_sig  = FETCH;
            end
          end
        end
        FETCH: begin
          w_ir_sig     = Data_Memoria_Micro;
          w_estado_sig = EXEC;
        end
        EXEC: begin
          if (w_es_halt) begin
            w_estado_sig = FIN;
          end else if (w_salto_tomado) begin
            if (w_destino_ilegal) begin
              w_error_sig   = 1'b1;
              w_ocupado_sig = 1'b0;
              w_estado_sig  = IDLE;
            end else begin
              w_upc_sig    = w_destino;
              w_estado_sig = FETCH;
            end
          end else if (w_es_espera) begin
            w_estado_sig = STALL;
          end else begin
            // CONTROL, or a branch whose condition is false: sequential step.
            if (w_es_control) w_senales_sig = r_ir[7:0];
            if (r_upc == ULTIMA) begin
              w_estado_sig = FIN;
            end else begin
              w_upc_sig    = r_upc + 6'd1;
              w_estado_sig = FETCH;
            end
          end
        end
        STALL: begin
          // While stalled the instruction register still holds the WAIT word,
          // so the decoder's taken flag follows Condiciones[2] directly.
          if (w_salto_tomado) begin
            if (w_destino_ilegal) begin
              w_error_sig   = 1'b1;
              w_ocupado_sig = 1'b0;
              w_estado_sig  = IDLE;
            end else begin
              w_upc_sig    = w_destino;
              w_estado_sig = FETCH;
            end
          end else if (r_cnt == CNT_LIMITE) begin
            w_error_sig   = 1'b1;
            w_ocupado_sig = 1'b0;
            w_estado_sig  = IDLE;
          end else begin
            w_cnt_sig = r_cnt + ANCHO_ESPERA'(1);
          end
        end
        FIN: begin
          w_listo_sig   = 1'b1;
          w_ocupado_sig = 1'b0;
          w_estado_sig  = IDLE;
        end
        default: begin
          w_estado_sig  = IDLE;
          w_ocupado_sig = 1'b0;
        end
      endcase
    end
  end

  assign Dir_Memoria_Micro = r_upc;
  assign Senales_Control   = r_senales;
  assign Ocupado           = r_ocupado;
  assign Listo             = r_listo;
  assign Error_Tiempo      = r_error;

endmodule

// File: tb/tb_secuenciador_micro.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_micro
// Directed bench: a small microprogram ROM feeds the sequencer; expected
// control words and Listo pulses are queued before each run and a negedge
// monitor pops and compares them as the DUT emits them.
// -----------------------------------------------------------------------------
module tb_secuenciador_micro;

  logic       clk = 1'b0;
  logic       reset;
  logic       Inicio;
  logic [5:0] Dir_Inicio;
  logic       Abortar;
  logic [2:0] Condiciones;
  logic [5:0] Dir_Memoria_Micro;
  logic [9:0] Data_Memoria_Micro;
  logic [7:0] Senales_Control;
  logic       Ocupado;
  logic       Listo;
  logic       Error_Tiempo;

  localparam logic [8:0] EV_LISTO = 9'h100;

  logic [8:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] mon_act, mon_exp;

  secuenciador_micro dut (
    .clk                (clk),
    .reset              (reset),
    .Inicio             (Inicio),
    .Dir_Inicio         (Dir_Inicio),
    .Abortar            (Abortar),
    .Condiciones        (Condiciones),
    .Dir_Memoria_Micro  (Dir_Memoria_Micro),
    .Data_Memoria_Micro (Data_Memoria_Micro),
    .Senales_Control    (Senales_Control),
    .Ocupado            (Ocupado),
    .Listo              (Listo),
    .Error_Tiempo       (Error_Tiempo)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- microprogram ROM ----------------
  //  14 CONTROL 0x95        15 BRANCH always ->20
  //  20 CONTROL 0x5B        21 BRANCH if C0 ->39
  //  39 WAIT C2 ->45        44 CONTROL 0xFF (must be skipped)
  //  45 BRANCH if C1 ->47   46 BRANCH always ->49
  //  49 CONTROL 0x47 (last address)    everything else HALT
  function automatic logic [9:0] rom(input logic [5:0] a);
    case (a)
      6'd14:   return 10'h195;
      6'd15:   return 10'h314;
      6'd20:   return 10'h15B;
      6'd21:   return 10'h367;
      6'd39:   return 10'h3ED;
      6'd44:   return 10'h1FF;
      6'd45:   return 10'h3AF;
      6'd46:   return 10'h331;
      6'd49:   return 10'h147;
      default: return 10'h000;
    endcase
  endfunction

  assign Data_Memoria_Micro = rom(Dir_Memoria_Micro);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_inicio(input logic [5:0] dir);
    Inicio     = 1'b1;
    Dir_Inicio = dir;
    tick(1);
    Inicio     = 1'b0;
  endtask

  task automatic wait_listo(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (Listo) seen = 1;
    end
    check({name, "_listo_seen"}, int'(seen), 1);
    check({name, "_ocupado_at_listo"}, int'(Ocupado), 0);
  endtask

  task automatic push_full_program();
    exp_q.push_back(9'h095);
    exp_q.push_back(9'h05B);
    exp_q.push_back(9'h047);
    exp_q.push_back(EV_LISTO);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (Senales_Control != 8'h00 || Listo) begin
      mon_act = Listo ? EV_LISTO : {1'b0, Senales_Control};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected none (t=%0t)", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL sb_event: got %0h expected %0h (t=%0t)", mon_act, mon_exp, $time);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cycles;
    bit seen;
    reset       = 1'b1;
    Inicio      = 1'b0;
    Dir_Inicio  = '0;
    Abortar     = 1'b0;
    Condiciones = 3'b000;
    tick(3);
    check("rst_dir",     int'(Dir_Memoria_Micro), 0);
    check("rst_senales", int'(Senales_Control), 0);
    check("rst_ocupado", int'(Ocupado), 0);
    check("rst_listo",   int'(Listo), 0);
    check("rst_error",   int'(Error_Tiempo), 0);
    reset = 1'b0;
    tick(1);

    // 1) Full program, wait released immediately, C1 low so 45 falls through.
    Condiciones = 3'b101;
    push_full_program();
    pulse_inicio(6'd14);
    check("run_ocupado", int'(Ocupado), 1);
    check("run_dir0",    int'(Dir_Memoria_Micro), 14);
    tick(1);
    check("run_lat_early", int'(Senales_Control), 0);
    tick(1);
    check("run_lat_first", int'(Senales_Control), 8'h95);
    wait_listo("run", 60);
    tick(1);
    check("run_listo_once", int'(Listo), 0);
    check("run_error",      int'(Error_Tiempo), 0);

    // 2) Stall at 39, released after 10 more cycles.
    Condiciones = 3'b001;
    exp_q.push_back(9'h095);
    exp_q.push_back(9'h05B);
    pulse_inicio(6'd14);
    tick(12);
    check("stall_dir",     int'(Dir_Memoria_Micro), 39);
    check("stall_ocupado", int'(Ocupado), 1);
    tick(10);
    check("stall_dir_hold", int'(Dir_Memoria_Micro), 39);
    exp_q.push_back(9'h047);
    exp_q.push_back(EV_LISTO);
    Condiciones = 3'b101;
    wait_listo("stall", 40);
    check("stall_error", int'(Error_Tiempo), 0);

    // 3) Timeout: sampling edge -> 10 edges to enter STALL, 255 stall cycles.
    Condiciones = 3'b001;
    exp_q.push_back(9'h095);
    exp_q.push_back(9'h05B);
    pulse_inicio(6'd14);
    cycles = 0;
    seen   = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      cycles++;
      if (Error_Tiempo) seen = 1;
    end
    check("to_seen",    int'(seen), 1);
    check("to_cycles",  cycles, 265);
    check("to_ocupado", int'(Ocupado), 0);
    tick(3);
    check("to_sticky",  int'(Error_Tiempo), 1);
    Condiciones = 3'b101;
    push_full_program();
    pulse_inicio(6'd14);
    check("to_restart_clear", int'(Error_Tiempo), 0);
    wait_listo("to_restart", 60);

    // 4) Illegal start address, then aborts while idle keep the error.
    pulse_inicio(6'd50);
    check("ill_error",   int'(Error_Tiempo), 1);
    check("ill_ocupado", int'(Ocupado), 0);
    Abortar = 1'b1;
    tick(1);
    Abortar = 1'b0;
    check("abort_idle_error", int'(Error_Tiempo), 1);
    Inicio     = 1'b1;
    Abortar    = 1'b1;
    Dir_Inicio = 6'd14;
    tick(1);
    Inicio  = 1'b0;
    Abortar = 1'b0;
    check("abort_wins_ocupado", int'(Ocupado), 0);
    tick(4);
    check("abort_wins_idle", int'(Ocupado), 0);

    // 5) Abort while running address 20; Inicio while busy is ignored.
    exp_q.push_back(9'h095);
    pulse_inicio(6'd14);
    Inicio     = 1'b1;
    Dir_Inicio = 6'd45;
    tick(1);
    Inicio = 1'b0;
    check("busy_ocupado", int'(Ocupado), 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (Dir_Memoria_Micro == 6'd20) seen = 1;
      else tick(1);
    end
    check("abort_reach20", int'(seen), 1);
    Abortar = 1'b1;
    tick(1);
    Abortar = 1'b0;
    check("abort_ocupado", int'(Ocupado), 0);
    check("abort_senales", int'(Senales_Control), 0);
    check("abort_listo",   int'(Listo), 0);
    check("abort_error",   int'(Error_Tiempo), 0);
    tick(6);
    check("abort_stays_idle", int'(Ocupado), 0);

    // 6) Reset in the middle of a program.
    exp_q.push_back(9'h095);
    pulse_inicio(6'd14);
    tick(2);
    check("mid_senales_before", int'(Senales_Control), 8'h95);
    reset = 1'b1;
    tick(1);
    check("mid_rst_dir",     int'(Dir_Memoria_Micro), 0);
    check("mid_rst_senales", int'(Senales_Control), 0);
    check("mid_rst_ocupado", int'(Ocupado), 0);
    check("mid_rst_listo",   int'(Listo), 0);
    check("mid_rst_error",   int'(Error_Tiempo), 0);
    reset = 1'b0;
    tick(5);
    check("mid_rst_idle", int'(Ocupado), 0);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/secuenciador_micro.md
Name: secuenciador_micro

Overview:
Microsequencer that drives the 6-bit address of the microprogram memory and decodes the 10-bit microword the memory returns. It sits between the top-level control (start/abort/status) and the datapath, which receives one 8-bit control word per executed microinstruction. Supported operations: sequential execute, conditional branch, wait-on-condition with timeout, and halt.

Parameters:
ULTIMA_DIR, 49, last valid microprogram address; executing it ends the program.
MAX_ESPERA, 255, maximum consecutive stall cycles in a wait microinstruction before timeout.
ANCHO_ESPERA, 8, width of the stall counter (must hold MAX_ESPERA).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high.
Inicio  input  1  start request; sampled in IDLE only.
Dir_Inicio  input  6  microprogram entry address; latched with Inicio.
Abortar  input  1  abort the running program.
Condiciones  input  3  datapath status flags.
Dir_Memoria_Micro  output  6  microprogram memory address (registered).
Data_Memoria_Micro  input  10  microword from the memory (combinational read).
Senales_Control  output  8  datapath control word, valid for one cycle.
Ocupado  output  1  high while the program runs.
Listo  output  1  one-cycle pulse on normal completion.
Error_Tiempo  output  1  sticky error flag: timeout or illegal target.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- Reset values: Dir_Memoria_Micro=0, Senales_Control=0, Ocupado=0, Listo=0, Error_Tiempo=0, state=IDLE, stall counter=0.
- Microword format:
  - [8]=0: HALT.
  - [9]=0, [8]=1: CONTROL, with [7:0] as the control word.
  - [9]=1, [8]=1: BRANCH, with [7:6] as condition select and [5:0] as target.
- BRANCH condition select:
  - 00: always jump.
  - 01: jump if Condiciones[0], else uPC+1.
  - 10: jump if Condiciones[1], else uPC+1.
  - 11: WAIT; stall at this address until Condiciones[2]=1, then jump to target.
- States: IDLE, FETCH, EXEC, STALL, FIN.
  - IDLE: if Inicio, set Dir_Memoria_Micro<=Dir_Inicio, Ocupado<=1, Error_Tiempo<=0, then go to FETCH.
  - FETCH: register Data_Memoria_Micro into the instruction register, then go to EXEC.
  - EXEC, CONTROL: Senales_Control<=[7:0] for exactly one cycle. If uPC==ULTIMA_DIR, go to FIN; else uPC+1 and go to FETCH.
  - EXEC, BRANCH taken: uPC<=target, then go to FETCH.
  - EXEC, BRANCH not taken: same as CONTROL sequencing, with Senales_Control=0.
  - EXEC, WAIT: if Condiciones[2]=1, jump to target; else go to STALL.
  - EXEC, HALT: go to FIN.
  - STALL: increment the counter each cycle. When Condiciones[2]=1, jump to target and go to FETCH. If the counter reaches MAX_ESPERA, set Error_Tiempo=1, Ocupado=0, go to IDLE. The counter clears on leaving STALL.
  - FIN: Listo=1 for one cycle, Ocupado=0, go to IDLE.
- Timing: each executed microword takes 2 cycles (FETCH+EXEC). Senales_Control is high in the cycle after EXEC is entered. The first control word appears 3 cycles after Inicio is sampled.
- Branch target > ULTIMA_DIR, or Dir_Inicio > ULTIMA_DIR: set Error_Tiempo=1, go to IDLE, no Listo.
- No wrap-around: uPC never increments past ULTIMA_DIR.
- Abortar has priority over every state except reset. Next cycle: IDLE, Senales_Control=0, Ocupado=0, no Listo, Error_Tiempo unchanged.
- Inicio outside IDLE is ignored. Simultaneous Inicio and Abortar in IDLE: Abortar wins and the start is dropped.
- Reset mid-program returns all outputs to their reset values on the next edge.
- Senales_Control is 0 in every cycle that does not follow a CONTROL EXEC.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, FETCH, EXEC, STALL, FIN);
  - microword field positions (BIT_SALTO=9, BIT_VALIDO=8, CAMPO_COND=[7:6], CAMPO_DESTINO=[5:0]);
  - condition codes (00 always, 01 cond0, 10 cond1, 11 wait).
- One natural sub-module, decodificador_microinstruccion: combinational decoder that turns the microword and Condiciones into es_halt, es_control, salto_tomado, es_espera and destino.

Test Plan:
- Full program from 14 with the current microprogram memory, Condiciones[2]=1. Inicio with Dir_Inicio=14 → control 0x95 at address 14, 0x5B at 20, 0x00 at 39 (branch taken to 45, address 44 skipped), 0x47 at 49. Then one Listo pulse; Ocupado low afterwards.
- Wait stall: same program with Condiciones[2]=0. Stalls at address 39. Raise Condiciones[2] after 10 cycles → resumes at 45 and completes with Listo.
- Timeout: Condiciones[2] held 0 → Error_Tiempo=1 after MAX_ESPERA stall cycles, Ocupado=0, no Listo. Next Inicio clears Error_Tiempo.
- Abort: Abortar pulsed while running address 20 → next cycle IDLE, Senales_Control=0, Ocupado=0, no Listo. Inicio while busy is ignored.
- Illegal start: Dir_Inicio=50 → Error_Tiempo=1 and return to IDLE. Reset asserted mid-program → all outputs 0 on the next edge.
